// File: rtl/pixel_xfer_pkg.sv
// Shared types and defaults for the camera-frame pixel transfer path.
package pixel_xfer_pkg;

    localparam int PIX_W     = 16;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        WAIT_DATA,
        HOLD,
        DONE
    } fsp_state_t;

endpackage

// File: rtl/fsp_rewind_ctrl.sv
// Holds rd_load high for LOAD_CYCLES cycles after start; done marks the last one.
module fsp_rewind_ctrl #(
    parameter int LOAD_CYCLES = 4
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic start,
    output logic rd_load,
    output logic done
);

    localparam int CW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign done = rd_load && (cnt == CW'(LOAD_CYCLES - 1));

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            rd_load <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            rd_load <= 1'b1;
            cnt     <= '0;
        end else if (done) begin
            rd_load <= 1'b0;
            cnt     <= '0;
        end else if (rd_load) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Pulls one frame from the SDRAM read FIFO and presents it pixel by pixel
// to the downstream transfer stage, advancing on get_next_pix.
module frame_pixel_streamer #(
    parameter int H_RES       = pixel_xfer_pkg::H_RES_DEF,
    parameter int V_RES       = pixel_xfer_pkg::V_RES_DEF,
    parameter int PIX_W       = pixel_xfer_pkg::PIX_W,
    parameter int LOAD_CYCLES = 4,
    parameter int CNT_W       = $clog2(H_RES * V_RES)
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             capture_start,
    output logic             rd_load,
    output logic             fifo_rdreq,
    input  logic [PIX_W-1:0] fifo_q,
    input  logic             fifo_rdempty,
    input  logic             get_next_pix,
    output logic [PIX_W-1:0] pixel_data,
    output logic             pix_rdy,
    output logic             img_done,
    output logic             frame_active,
    output logic [CNT_W-1:0] pix_index,
    output logic             err_underrun
);

    import pixel_xfer_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(H_RES * V_RES - 1);

    fsp_state_t state;
    logic       accept;
    logic       load_done;

    assign accept = capture_start && (state == IDLE || state == DONE);

    fsp_rewind_ctrl #(.LOAD_CYCLES(LOAD_CYCLES)) u_rewind (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .start   (accept),
        .rd_load (rd_load),
        .done    (load_done)
    );

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            fifo_rdreq   <= 1'b0;
            pixel_data   <= '0;
            pix_rdy      <= 1'b0;
            img_done     <= 1'b0;
            frame_active <= 1'b0;
            pix_index    <= '0;
            err_underrun <= 1'b0;
        end else begin
            fifo_rdreq <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state        <= LOAD;
                        pix_index    <= '0;
                        pix_rdy      <= 1'b0;
                        img_done     <= 1'b0;
                        err_underrun <= 1'b0;
                        frame_active <= 1'b1;
                    end
                end
                LOAD: begin
                    if (get_next_pix) err_underrun <= 1'b1;
                    if (load_done) state <= FETCH;
                end
                FETCH: begin
                    if (get_next_pix) err_underrun <= 1'b1;
                    if (!fifo_rdempty) begin
                        fifo_rdreq <= 1'b1;
                        state      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (get_next_pix) err_underrun <= 1'b1;
                    // rdreq is registered, so the first WAIT_DATA cycle is the
                    // pop itself; fifo_q is valid only on the following cycle.
                    if (!fifo_rdreq) begin
                        pixel_data <= fifo_q;
                        pix_rdy    <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (get_next_pix) begin
                        pix_rdy <= 1'b0;
                        if (pix_index == LAST_IDX) begin
                            state        <= DONE;
                            img_done     <= 1'b1;
                            frame_active <= 1'b0;
                        end else begin
                            pix_index <= pix_index + 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
